unidad_fetch: RTL

Instruction-fetch stage that sits directly upstream of the instruction memory (Memoria_Instrucciones). It owns the program counter, drives the memory address, and captures the returned instruction into the IF/ID pipeline register. It supports stall, branch/jump redirect with flush, and a halt state entered on EBREAK. Downstream, the decode stage consumes `if_pc`, `if_inst` and `if_valid`.

---
 rtl/unidad_fetch_pkg.sv | 19 +
 rtl/unidad_fetch_if.sv | 27 ++
 rtl/unidad_fetch_registro_if_id.sv | 55 +++++
 rtl/unidad_fetch.sv | 82 ++++++++
 4 files changed

// File: rtl/unidad_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NopInst    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] EbreakInst = 32'h0010_0073;
  localparam logic [31:0] DefaultPc  = 32'h0000_0000;
  localparam int unsigned DefaultPcStep = 4;

  // Word-align a fetch target; the low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/unidad_fetch_if.sv
// Bundle of the fetch stage's control, memory and IF/ID signals.
interface unidad_fetch_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] addr;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_count;

  // Environment side: pipeline control and instruction memory.
  modport master (
    output stall, redirect, redirect_pc, inst,
    input  addr, if_pc, if_inst, if_valid, halted, fetch_count
  );

  // Fetch unit side.
  modport slave (
    input  stall, redirect, redirect_pc, inst,
    output addr, if_pc, if_inst, if_valid, halted, fetch_count
  );

endinterface

// File: rtl/unidad_fetch_registro_if_id.sv
// IF/ID pipeline register with load, flush-to-bubble and hold controls.
module registro_if_id
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  // Next contents: flush beats load; neither means hold.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  // Register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign if_pc_o    = pc_q;
  assign if_inst_o  = inst_q;
  assign if_valid_o = valid_q;

endmodule

// File: rtl/unidad_fetch.sv
// Instruction-fetch stage: PC, next-PC selection, RUN/HALT FSM and capture counter.
module unidad_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DefaultPc,
  parameter int unsigned PC_STEP     = DefaultPcStep,
  parameter logic [31:0] NOP_INST    = NopInst,
  parameter logic [31:0] EBREAK_INST = EbreakInst
) (
  input logic            clk,
  input logic            rst,
  unidad_fetch_if.slave  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         load;
  logic         flush;

  // Next-state, next-PC and IF/ID control; priority redirect > stall > ebreak > normal.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.redirect) begin
          pc_d  = align_pc(bus.redirect_pc);
          flush = 1'b1;
        end else if (bus.stall) begin
          // Everything holds.
        end else if (bus.inst == EBREAK_INST) begin
          load    = 1'b1;
          state_d = StHalt;
        end else begin
          load = 1'b1;
          pc_d = pc_q + PC_STEP;
        end
      end
      StHalt: begin
        // Redirect is ignored; drain the EBREAK once unless stalled.
        flush = !bus.stall;
      end
      default: state_d = StRun;
    endcase
    cnt_d = cnt_q + 32'(load);
  end

  // PC, FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  registro_if_id #(
    .NOP_INST (NOP_INST)
  ) u_registro_if_id (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .flush_i    (flush),
    .pc_i       (pc_q),
    .inst_i     (bus.inst),
    .if_pc_o    (bus.if_pc),
    .if_inst_o  (bus.if_inst),
    .if_valid_o (bus.if_valid)
  );

  assign bus.addr        = pc_q;
  assign bus.halted      = (state_q == StHalt);
  assign bus.fetch_count = cnt_q;

endmodule
